// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA raster engine: the standard 640x480@60 timing,
// the default colour depth, the default background band boundaries/colours and
// a helper that packs three colour channels into one {R,G,B} pixel word.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Bits per colour channel in the default build.
    localparam int unsigned CW_DEFAULT = 2;

    // 640x480@60 horizontal timing, in pixels.
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;

    // 640x480@60 vertical timing, in lines.
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // Background band boundaries (line numbers, exclusive upper bounds).
    localparam int unsigned VGA_BAND0_END = 240;
    localparam int unsigned VGA_BAND1_END = 264;

    // Pack three channels into a {R,G,B} word, red in the MSBs.
    function automatic logic [3*CW_DEFAULT-1:0] rgb_pack(
        input logic [CW_DEFAULT-1:0] r,
        input logic [CW_DEFAULT-1:0] g,
        input logic [CW_DEFAULT-1:0] b
    );
        return {r, g, b};
    endfunction

    // Default background colours for the three bands.
    localparam logic [3*CW_DEFAULT-1:0] VGA_BG0 = rgb_pack(2'b00, 2'b01, 2'b11);
    localparam logic [3*CW_DEFAULT-1:0] VGA_BG1 = rgb_pack(2'b00, 2'b11, 2'b00);
    localparam logic [3*CW_DEFAULT-1:0] VGA_BG2 = rgb_pack(2'b00, 2'b10, 2'b00);

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical): a 10-bit counter running over
// ACTIVE+FP+SYNC+BP positions, with decoded terminal-count, sync and active
// flags. The horizontal instance advances on every enabled pixel; the vertical
// instance advances only when the horizontal one wraps.
//
// Parameters: ACTIVE, FP, SYNC, BP (positions), POL (active sync level).
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   ce        in   clock enable (pixel enable)
//   wrap_in   in   advance qualifier; the counter steps when ce & wrap_in
//   count     out  current position, 0..TOTAL-1
//   wrap_out  out  count is at TOTAL-1 (the next step wraps to 0)
//   sync_raw  out  unregistered sync level, already at the POL polarity
//   active    out  count lies inside the visible region
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned FP     = VGA_H_FP,
    parameter int unsigned SYNC   = VGA_H_SYNC,
    parameter int unsigned BP     = VGA_H_BP,
    parameter logic        POL    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       wrap_in,
    output logic [9:0] count,
    output logic       wrap_out,
    output logic       sync_raw,
    output logic       active
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

    // Decode points, all expressed at the 10-bit counter width.
    localparam logic [9:0] LAST_C       = 10'(TOTAL - 1);
    localparam logic [9:0] ACTIVE_END_C = 10'(ACTIVE);
    localparam logic [9:0] SYNC_BEG_C   = 10'(ACTIVE + FP);
    localparam logic [9:0] SYNC_END_C   = 10'(ACTIVE + FP + SYNC);

    // Elaboration guards: every region must exist and the axis must fit.
    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_zero_region
        $error("vga_axis_counter: ACTIVE/FP/SYNC/BP must all be non-zero");
    end
    if (TOTAL > 1024) begin : g_total_too_big
        $error("vga_axis_counter: ACTIVE+FP+SYNC+BP exceeds the 10-bit counter range");
    end

    logic [9:0] r_count;
    logic       w_last;
    logic       w_in_sync;

    assign w_last    = (r_count == LAST_C);
    assign w_in_sync = (r_count >= SYNC_BEG_C) && (r_count < SYNC_END_C);

    // Position counter: step on enabled, qualified cycles and wrap at TOTAL-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 10'd0;
        end else if (ce && wrap_in) begin
            if (w_last) begin
                r_count <= 10'd0;
            end else begin
                r_count <= r_count + 10'd1;
            end
        end
    end

    assign count    = r_count;
    assign wrap_out = w_last;
    assign sync_raw = w_in_sync ? POL : ~POL;
    assign active   = (r_count < ACTIVE_END_C);

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster engine. Generates the live H/V counters consumed by
// the scene logic, and from them a registered pixel stream: banded background,
// optional overlay pixel from the scene logic, blanking, syncs, data-enable and
// frame/line strobes. Every registered output lags the live counters by exactly
// one pix_ce-enabled cycle, so all of them stay mutually aligned.
//
// Optional feature: define VGA_TEST_PATTERN_EN to add the tp_mode input, which
// replaces the active-area colour with 8 vertical colour bars.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   pix_ce       in   pixel enable; all state advances only when it is 1
//   rgb_in       in   overlay pixel {R,G,B} for the current h_count/v_count
//   draw         in   1 = rgb_in replaces the background at this position
//   tp_mode      in   (VGA_TEST_PATTERN_EN only) 1 = colour-bar pattern
//   h_count      out  live horizontal count, 0..H_TOTAL-1
//   v_count      out  live vertical count, 0..V_TOTAL-1
//   red_out      out  registered red channel, 0 in blanking
//   green_out    out  registered green channel, 0 in blanking
//   blue_out     out  registered blue channel, 0 in blanking
//   hsync        out  registered horizontal sync (HS_POL active)
//   vsync        out  registered vertical sync (VS_POL active)
//   de           out  registered active-video flag
//   frame_start  out  pulse aligned with output pixel (0,0)
//   line_start   out  pulse aligned with output pixel (0,y) of each active line
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CW        = CW_DEFAULT,
    parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0,
    parameter int unsigned BAND0_END = VGA_BAND0_END,
    parameter int unsigned BAND1_END = VGA_BAND1_END,
    parameter logic [3*CW-1:0] BG0   = (3*CW)'(VGA_BG0),
    parameter logic [3*CW-1:0] BG1   = (3*CW)'(VGA_BG1),
    parameter logic [3*CW-1:0] BG2   = (3*CW)'(VGA_BG2)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pix_ce,
    input  logic [3*CW-1:0] rgb_in,
    input  logic            draw,
`ifdef VGA_TEST_PATTERN_EN
    input  logic            tp_mode,
`endif
    output logic [9:0]      h_count,
    output logic [9:0]      v_count,
    output logic [CW-1:0]   red_out,
    output logic [CW-1:0]   green_out,
    output logic [CW-1:0]   blue_out,
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic            frame_start,
    output logic            line_start
);

    localparam int unsigned PW = 3 * CW;

    localparam logic [9:0] BAND0_END_C = 10'(BAND0_END);
    localparam logic [9:0] BAND1_END_C = 10'(BAND1_END);

    // Elaboration guards not covered by the axis counters themselves.
    if (CW == 0) begin : g_zero_cw
        $error("vga_timing_gen: CW must be non-zero");
    end
    if (BAND0_END > BAND1_END) begin : g_band_order
        $error("vga_timing_gen: BAND0_END must not exceed BAND1_END");
    end

    // ------------------------------------------------------------------
    // Axis counters
    // ------------------------------------------------------------------
    logic [9:0] w_h_count;
    logic [9:0] w_v_count;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_h_sync;
    logic       w_v_sync;
    logic       w_h_active;
    logic       w_v_active;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) u_h_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (pix_ce),
        .wrap_in  (1'b1),
        .count    (w_h_count),
        .wrap_out (w_h_wrap),
        .sync_raw (w_h_sync),
        .active   (w_h_active)
    );

    // The vertical axis steps once per line, on the enabled cycle where the
    // horizontal axis wraps; its own wrap therefore coincides with that edge.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) u_v_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (pix_ce),
        .wrap_in  (w_h_wrap),
        .count    (w_v_count),
        .wrap_out (w_v_wrap),
        .sync_raw (w_v_sync),
        .active   (w_v_active)
    );

    // The vertical terminal count carries no extra meaning for the pixel
    // path; frame boundaries are decoded directly from the counters below.
    logic w_v_wrap_unused;
    assign w_v_wrap_unused = w_v_wrap;

    assign h_count = w_h_count;
    assign v_count = w_v_count;

    // ------------------------------------------------------------------
    // Pixel selection (combinational, from the live counters)
    // ------------------------------------------------------------------
    logic          w_active;
    logic [PW-1:0] w_band;
    logic [PW-1:0] w_pix;
    logic          w_frame_first;
    logic          w_line_first;

    assign w_active      = w_h_active & w_v_active;
    assign w_frame_first = (w_h_count == 10'd0) && (w_v_count == 10'd0);
    assign w_line_first  = (w_h_count == 10'd0) && w_v_active;

    // Background band lookup on the current line.
    always_comb begin
        w_band = BG2;
        if (w_v_count < BAND0_END_C) begin
            w_band = BG0;
        end else if (w_v_count < BAND1_END_C) begin
            w_band = BG1;
        end else begin
            w_band = BG2;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars: eight equal-width bars; the bar index bits drive R/G/B.
    localparam int unsigned BAR_W = ((H_ACTIVE / 8) == 0) ? 1 : (H_ACTIVE / 8);

    logic [2:0]    w_bar_idx;
    logic [PW-1:0] w_tp_pix;

    assign w_bar_idx = 3'(w_h_count / 10'(BAR_W));
    assign w_tp_pix  = {{CW{w_bar_idx[2]}}, {CW{w_bar_idx[1]}}, {CW{w_bar_idx[0]}}};

    // Colour priority inside the active area: test pattern, overlay, band.
    always_comb begin
        w_pix = {PW{1'b0}};
        if (w_active) begin
            if (tp_mode) begin
                w_pix = w_tp_pix;
            end else if (draw) begin
                w_pix = rgb_in;
            end else begin
                w_pix = w_band;
            end
        end else begin
            w_pix = {PW{1'b0}};
        end
    end
`else
    // Colour priority inside the active area: overlay, then band.
    always_comb begin
        w_pix = {PW{1'b0}};
        if (w_active) begin
            if (draw) begin
                w_pix = rgb_in;
            end else begin
                w_pix = w_band;
            end
        end else begin
            w_pix = {PW{1'b0}};
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output pipeline stage
    // ------------------------------------------------------------------
    logic [PW-1:0] r_pix;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic          r_frame_start;
    logic          r_line_start;

    // Register colour, syncs, de and strobes one enabled cycle behind the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix         <= {PW{1'b0}};
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else if (pix_ce) begin
            r_pix         <= w_pix;
            r_hsync       <= w_h_sync;
            r_vsync       <= w_v_sync;
            r_de          <= w_active;
            r_frame_start <= w_frame_first;
            r_line_start  <= w_line_first;
        end
    end

    assign red_out     = r_pix[PW-1:2*CW];
    assign green_out   = r_pix[2*CW-1:CW];
    assign blue_out    = r_pix[CW-1:0];
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen on a scaled-down raster (80x55 total,
// 64x48 visible) so whole frames stay short. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 80
    localparam int VT = VA + VF + VS + VB;   // 55
    localparam int FRAME = HT * VT;          // 4400

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pix_ce = 1'b0;
    logic [5:0] rgb_in = 6'b000000;
    logic       draw = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    logic       tp_mode = 1'b0;
`endif
    logic [9:0] h_count, v_count;
    logic [1:0] red_out, green_out, blue_out;
    logic       hsync, vsync, de, frame_start, line_start;
    logic [5:0] rgb_o;

    int errors = 0;
    int checks = 0;

    assign rgb_o = {red_out, green_out, blue_out};

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CW(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .BAND0_END(24), .BAND1_END(30),
        .BG0(6'b000111), .BG1(6'b001100), .BG2(6'b001000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .rgb_in(rgb_in), .draw(draw),
`ifdef VGA_TEST_PATTERN_EN
        .tp_mode(tp_mode),
`endif
        .h_count(h_count), .v_count(v_count),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .hsync(hsync), .vsync(vsync), .de(de),
        .frame_start(frame_start), .line_start(line_start)
    );

    // Band colour of a line: rows 0-23, 24-29, 30 and up.
    function automatic logic [5:0] exp_band(input int v);
        if (v < 24) return 6'b000111;
        else if (v < 30) return 6'b001100;
        else return 6'b001000;
    endfunction

    // Advance to the falling edge where the live counters equal (h,v).
    task automatic wait_pos(input int h, input int v, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < FRAME + 4) begin
            if (h_count == 10'(h) && v_count == 10'(v)) ok = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_pos: position (%0d,%0d) not reached, now at (%0d,%0d)", h, v, h_count, v_count);
        end
    endtask

    task automatic test_reset();
        pix_ce = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (h_count !== 10'd0 || v_count !== 10'd0) begin
            errors++; $display("FAIL reset_counts: got (%0d,%0d), expected (0,0)", h_count, v_count);
        end
        checks++;
        if (rgb_o !== 6'b000000) begin
            errors++; $display("FAIL reset_colour: got %b, expected 000000", rgb_o);
        end
        checks++;
        if (de !== 1'b0) begin
            errors++; $display("FAIL reset_de: got %b, expected 0", de);
        end
        checks++;
        if (hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++; $display("FAIL reset_syncs: got hs=%b vs=%b, expected hs=1 vs=1", hsync, vsync);
        end
        checks++;
        if (frame_start !== 1'b0 || line_start !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: got fs=%b ls=%b, expected 0 0", frame_start, line_start);
        end
    endtask

    // Two full frames with pix_ce held high and draw low.
    task automatic test_frames();
        int eh, ev, ph, pv;
        int bad_cnt, bad_pix, de_n, hs_n, vs_n, fs_n, ls_n;
        bit have_prev;
        logic [5:0] ec;
        logic ede, ehs, evs, efs, els;
        eh = 0; ev = 0; ph = 0; pv = 0; have_prev = 1'b0;
        bad_cnt = 0; bad_pix = 0; de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0; ls_n = 0;
        draw = 1'b0;
        rgb_in = 6'b110000;   // must be ignored while draw is low
        pix_ce = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (h_count !== 10'(eh) || v_count !== 10'(ev)) bad_cnt++;
            if (have_prev) begin
                ede = (ph < HA) && (pv < VA);
                ec  = ede ? exp_band(pv) : 6'b000000;
                ehs = !((ph >= HA + HF) && (ph < HA + HF + HS));
                evs = !((pv >= VA + VF) && (pv < VA + VF + VS));
                efs = (ph == 0) && (pv == 0);
                els = (ph == 0) && (pv < VA);
                if (rgb_o !== ec || de !== ede || hsync !== ehs || vsync !== evs ||
                    frame_start !== efs || line_start !== els) bad_pix++;
                if (de) de_n++;
                if (!hsync) hs_n++;
                if (!vsync) vs_n++;
                if (frame_start) fs_n++;
                if (line_start) ls_n++;
            end
            ph = eh; pv = ev; have_prev = 1'b1;
            if (eh == HT - 1) begin
                eh = 0;
                ev = (ev == VT - 1) ? 0 : ev + 1;
            end else begin
                eh++;
            end
            @(negedge clk);
        end
        checks++;
        if (bad_cnt !== 0) begin errors++; $display("FAIL frame_counters: got %0d bad cycles, expected 0", bad_cnt); end
        checks++;
        if (bad_pix !== 0) begin errors++; $display("FAIL frame_pixels: got %0d bad pixels, expected 0", bad_pix); end
        checks++;
        if (de_n !== 2 * HA * VA) begin errors++; $display("FAIL frame_de_count: got %0d, expected %0d", de_n, 2 * HA * VA); end
        checks++;
        if (hs_n !== 2 * HS * VT) begin errors++; $display("FAIL frame_hsync_low: got %0d, expected %0d", hs_n, 2 * HS * VT); end
        checks++;
        if (vs_n !== 2 * VS * HT) begin errors++; $display("FAIL frame_vsync_low: got %0d, expected %0d", vs_n, 2 * VS * HT); end
        checks++;
        if (fs_n !== 2) begin errors++; $display("FAIL frame_start_count: got %0d, expected 2", fs_n); end
        checks++;
        if (ls_n !== 2 * VA) begin errors++; $display("FAIL line_start_count: got %0d, expected %0d", ls_n, 2 * VA); end
    endtask

    // Overlay pixel at one position, neighbours, and draw during blanking.
    task automatic test_draw();
        bit ok;
        rgb_in = 6'b110000;
        draw = 1'b0;
        wait_pos(9, 5, ok);
        @(negedge clk);
        checks++;
        if (rgb_o !== 6'b000111) begin errors++; $display("FAIL draw_left: got %b, expected 000111", rgb_o); end
        draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        checks++;
        if (rgb_o !== 6'b110000) begin errors++; $display("FAIL draw_hit: got %b, expected 110000", rgb_o); end
        @(negedge clk);
        checks++;
        if (rgb_o !== 6'b000111) begin errors++; $display("FAIL draw_right: got %b, expected 000111", rgb_o); end
        wait_pos(10, 6, ok);
        @(negedge clk);
        checks++;
        if (rgb_o !== 6'b000111) begin errors++; $display("FAIL draw_below: got %b, expected 000111", rgb_o); end
        wait_pos(70, 6, ok);
        draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        checks++;
        if (rgb_o !== 6'b000000 || de !== 1'b0) begin
            errors++; $display("FAIL draw_blank: got rgb=%b de=%b, expected rgb=000000 de=0", rgb_o, de);
        end
        wait_pos(20, 26, ok);
        rgb_in = 6'b010101;
        draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        checks++;
        if (rgb_o !== 6'b010101) begin errors++; $display("FAIL draw_band1: got %b, expected 010101", rgb_o); end
        @(negedge clk);
        checks++;
        if (rgb_o !== 6'b001100) begin errors++; $display("FAIL band1_after: got %b, expected 001100", rgb_o); end
    endtask

    // pix_ce alternating 1,0,1,0: state advances only on enabled clocks.
    task automatic test_ce_toggle();
        logic [24:0] snap, now;
        logic [19:0] pre;
        int bad_hold, fs_n, de_n;
        bad_hold = 0; fs_n = 0; de_n = 0; pre = 20'd0;
        draw = 1'b0;
        pix_ce = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            pix_ce = (c % 2 == 0);
            snap = {h_count, v_count, rgb_o, hsync, vsync, de, frame_start, line_start};
            @(negedge clk);
            now = {h_count, v_count, rgb_o, hsync, vsync, de, frame_start, line_start};
            if (c % 2 == 1 && now !== snap) bad_hold++;
            if (frame_start) fs_n++;
            if (de) de_n++;
            if (c == 2 * FRAME - 3) pre = {h_count, v_count};
        end
        pix_ce = 1'b1;
        checks++;
        if (bad_hold !== 0) begin errors++; $display("FAIL ce_hold: got %0d changed idle cycles, expected 0", bad_hold); end
        checks++;
        if (pre !== {10'd79, 10'd54}) begin
            errors++; $display("FAIL ce_last_pixel: got (%0d,%0d), expected (79,54)", pre[19:10], pre[9:0]);
        end
        checks++;
        if (h_count !== 10'd0 || v_count !== 10'd0) begin
            errors++; $display("FAIL ce_frame_wrap: got (%0d,%0d), expected (0,0)", h_count, v_count);
        end
        checks++;
        if (fs_n !== 2) begin errors++; $display("FAIL ce_frame_start: got %0d samples, expected 2", fs_n); end
        checks++;
        if (de_n !== 2 * HA * VA) begin errors++; $display("FAIL ce_de_count: got %0d, expected %0d", de_n, 2 * HA * VA); end
    endtask

    // Reset asserted mid-frame, held 3 clocks, then a clean restart.
    task automatic test_reset_mid();
        bit ok;
        pix_ce = 1'b1;
        draw = 1'b0;
        wait_pos(30, 20, ok);
        checks++;
        if (rgb_o !== 6'b000111 || de !== 1'b1) begin
            errors++; $display("FAIL pre_reset: got rgb=%b de=%b, expected rgb=000111 de=1", rgb_o, de);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (h_count !== 10'd0 || v_count !== 10'd0) begin
            errors++; $display("FAIL async_reset_counts: got (%0d,%0d), expected (0,0)", h_count, v_count);
        end
        checks++;
        if (rgb_o !== 6'b000000 || de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++; $display("FAIL async_reset_outputs: got rgb=%b de=%b hs=%b vs=%b, expected 000000 0 1 1",
                               rgb_o, de, hsync, vsync);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (h_count !== 10'd0 || v_count !== 10'd0 || frame_start !== 1'b0) begin
            errors++; $display("FAIL reset_held: got (%0d,%0d) fs=%b, expected (0,0) fs=0", h_count, v_count, frame_start);
        end
        @(negedge clk);
        checks++;
        if (h_count !== 10'd1 || v_count !== 10'd0) begin
            errors++; $display("FAIL restart_counts: got (%0d,%0d), expected (1,0)", h_count, v_count);
        end
        checks++;
        if (frame_start !== 1'b1 || line_start !== 1'b1 || de !== 1'b1 || rgb_o !== 6'b000111) begin
            errors++; $display("FAIL restart_pixel: got fs=%b ls=%b de=%b rgb=%b, expected 1 1 1 000111",
                               frame_start, line_start, de, rgb_o);
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars on the first line; blanking stays black.
    task automatic test_pattern();
        int bad_bar, bad_blank;
        logic [2:0] b;
        logic [5:0] ec;
        bad_bar = 0; bad_blank = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tp_mode = 1'b1;
        draw = 1'b1;
        rgb_in = 6'b110000;
        pix_ce = 1'b1;
        for (int c = 0; c < HT; c++) begin
            @(negedge clk);
            if (c < HA) begin
                b = 3'(c / 8);
                ec = {b[2], b[2], b[1], b[1], b[0], b[0]};
                if (rgb_o !== ec || de !== 1'b1) bad_bar++;
            end else begin
                if (rgb_o !== 6'b000000 || de !== 1'b0) bad_blank++;
            end
        end
        tp_mode = 1'b0;
        draw = 1'b0;
        checks++;
        if (bad_bar !== 0) begin errors++; $display("FAIL tp_bars: got %0d bad pixels, expected 0", bad_bar); end
        checks++;
        if (bad_blank !== 0) begin errors++; $display("FAIL tp_blank: got %0d bad pixels, expected 0", bad_blank); end
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_draw();
        test_ce_toggle();
        test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
